axi_firewall_multi_unblocker: RTL and testbench
===============================================

# axi_firewall_multi_unblocker

Automatically clears blocked AXI Protocol Firewall (PG293) instances. Up to NUM_FW firewalls sit behind one AXI4-Lite control interconnect. The block watches each firewall's sticky MI error flags and round-robin arbitrates among the firewalls that need service. For the selected firewall it writes the MI Unblock Control register, then polls the MI error status register until the firewall reports clear. Per-firewall status flags report timeouts and bad responses to the management logic.

## Interface
- NUM_FW, 2: number of firewalls serviced (1..16).
- ADDR_WIDTH, 16: M_AXI_CTL address width; must satisfy ADDR_WIDTH >= FW_ADDR_SHIFT + clog2(NUM_FW).
- FW_ADDR_SHIFT, 12: firewall i control base = i << FW_ADDR_SHIFT.
- RESP_TIMEOUT, 1024: cycles to wait for B after AW and W are both accepted.
- POLL_MAX, 64: maximum status reads per unblock attempt.
- CNT_WIDTH, 16: width of each unblock counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- M_AXI_CTL_aw{addr[ADDR_WIDTH],valid,ready}, w{data[32],strb[4],valid,ready}, b{resp[2],valid,ready}, ar{addr[ADDR_WIDTH],valid,ready}, r{data[32],resp[2],valid,ready}: AXI4-Lite master, standard directions.
- mi_w_error  in  NUM_FW  sticky write-error flag per firewall.
- mi_r_error  in  NUM_FW  sticky read-error flag per firewall.
- busy  out  1  high while any unblock is in progress.
- timeout_err  out  NUM_FW  sticky; B timeout or POLL_MAX exhausted.
- resp_err  out  NUM_FW  sticky; nonzero BRESP or RRESP.
- unblock_cnt  out  NUM_FW*CNT_WIDTH  completed unblocks per firewall, saturating; firewall i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

## Operation
- Request: req[i] = armed[i] & (mi_w_error[i] | mi_r_error[i]).
- armed[i] clears when firewall i is granted. It sets again once mi_w_error[i] and mi_r_error[i] are both low with i not in service. This ensures one error episode triggers only one unblock.
- The round-robin grant starts from the channel after the last one granted. The grant index is held in sel for the whole sequence.
- FSM states and transitions:
  - IDLE: if any req, go to WRITE.
  - WRITE: assert AWVALID and WVALID together. Each deasserts independently on its own handshake. When both are done, go to RESP.
  - RESP: on BVALID, go to POLL_AR. If BRESP != 0, set resp_err[sel]. If the timer reaches RESP_TIMEOUT, set timeout_err[sel] and go to IDLE.
  - POLL_AR: assert ARVALID; on handshake, go to POLL_R.
  - POLL_R: on RVALID, check RDATA and the poll count.
    - If RDATA == 0, increment unblock_cnt[sel] and go to IDLE.
    - Else if the poll count is less than POLL_MAX, go to POLL_AR.
    - Else set timeout_err[sel] and go to IDLE.
    - If RRESP != 0, set resp_err[sel] and go to IDLE.
- Fixed fields:
  - AWADDR = base + 0x8 (MI Unblock Control); WDATA = 1; WSTRB = 4'b0001.
  - ARADDR = base + 0x0 (MI error status).
- BREADY and RREADY are tied high. A late B arriving after a timeout is consumed and ignored.
- unblock_cnt saturates at all-ones. The timeout and error flags clear only on reset.

## Timing
- Reset values:
  - All VALID outputs 0; busy 0; flags 0; counters 0; armed all 1; sel 0.
  - FSM state IDLE; next round-robin pointer starts at channel 0.
- Latency: a request visible at clock edge t produces AWVALID and WVALID high after edge t+1.
  - AWVALID/WVALID stay asserted until their handshake, with no combinational path from READY to VALID.
- busy is high in every state except IDLE.
- Simultaneous events:
  - When requests arrive on several channels in the same cycle, exactly one channel is granted per sequence.
  - A channel that requests while another is in service waits; it is not lost.
  - If AW and W handshake in the same cycle, the FSM enters RESP on the next cycle.
- Reset mid-transaction drops all valids asynchronously and returns the FSM to IDLE with no outstanding state.
- The RESP timer resets on entry to RESP and stops counting at RESP_TIMEOUT.

## Configuration
- AXI_FW_UNBLOCK_CNT_EN:
  - Defined: unblock_cnt counters are implemented as described.
  - Undefined: unblock_cnt is driven to 0 and no counter flops exist. All other behaviour is unchanged and the port list is identical.

## Structure
- Package axi_fw_unblock_pkg contains:
  - the FSM state encoding;
  - register offset constants (UNBLOCK_OFFSET = 12'h8, STATUS_OFFSET = 12'h0);
  - AXI response code constants (OKAY, SLVERR, DECERR).
- One sub-module, axi_fw_rr_arbiter: a parametrised NUM_FW round-robin arbiter with request vector, grant-enable, one-hot grant and binary index outputs.

## Test plan
- NUM_FW=2; pulse mi_w_error[1]=1 held; status reads return 0:
  - one write to address 0x1008 with WDATA=1, then one read of 0x1000;
  - unblock_cnt[1]=1, busy low afterwards;
  - no second write until mi_w_error[1] falls and rises again.
- mi_r_error=2'b11 asserted in the same cycle: channel 0 serviced first, then channel 1; exactly 2 writes total.
- AWREADY delayed 3 cycles, WREADY immediate: WVALID drops after 1 cycle and AWVALID drops on the 3-cycle handshake; a single B completes.
- BVALID withheld: timeout_err[0] sets after 1024 cycles and the FSM returns to IDLE. A later BVALID is ignored and leaves no state change.
- Status reads return 0x1 for 64 polls: timeout_err set after the 64th read, unblock_cnt unchanged.
- BRESP=2'b10: resp_err[sel]=1, polling continues normally. aresetn low mid-WRITE: all valids 0 on the same edge and state IDLE.

Source files
------------

// File: rtl/axi_fw_unblock_pkg.sv
// Shared types and constants for the AXI firewall unblocker.
// This package holds the FSM encoding, the firewall register offsets and the AXI response codes.
package axi_fw_unblock_pkg;

  // Sequencer states. One full unblock runs WRITE -> RESP -> (POLL_AR -> POLL_R)*.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RESP    = 3'd2,
    ST_POLL_AR = 3'd3,
    ST_POLL_R  = 3'd4
  } fsm_state_e;

  // Firewall control register offsets, relative to the per-firewall base.
  localparam logic [11:0] UNBLOCK_OFFSET = 12'h8;  // MI Unblock Control
  localparam logic [11:0] STATUS_OFFSET  = 12'h0;  // MI error status

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Fixed write payload for the unblock command.
  localparam logic [31:0] UNBLOCK_WDATA = 32'h0000_0001;
  localparam logic [3:0]  UNBLOCK_WSTRB = 4'b0001;

  // Width of a channel index. A single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_fw_rr_arbiter.sv
// Round-robin arbiter over NUM_FW request lines.
// The search starts at the channel after the last grant. The pointer only moves when a grant is taken,
// which happens when grant_en is high and at least one channel is requesting.
module axi_fw_rr_arbiter #(
  parameter int NUM_FW = 2,
  parameter int IDX_W  = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NUM_FW-1:0] req,
  input  logic              grant_en,
  output logic [NUM_FW-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_FW-1:0] pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  int                cand;

  // Find the first requester at or after ptr_q, wrapping around.
  // The scan runs from the farthest offset down, so the nearest requester is the last one written and wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = 0;
    for (int k = NUM_FW - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_FW) cand = cand - NUM_FW;
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
        pick_any   = 1'b1;
      end
    end
  end

  assign grant       = pick & {NUM_FW{grant_en}};
  assign grant_idx   = pick_idx;
  assign grant_valid = pick_any & grant_en;

  // After a grant, move the pointer to the channel after the one just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (int'(pick_idx) == NUM_FW - 1) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_firewall_multi_unblocker.sv
// Automatic unblocker for up to NUM_FW AXI Protocol Firewall instances on one AXI4-Lite control bus.
// For each firewall that raises a sticky MI error, the block writes the Unblock Control register
// and then polls the error status register until it reads zero.
// Optional feature macro: AXI_FW_UNBLOCK_CNT_EN. When it is defined, the per-firewall saturating
// completion counters are built. When it is not defined, unblock_cnt is tied to zero.
module axi_firewall_multi_unblocker
  import axi_fw_unblock_pkg::*;
#(
  parameter int NUM_FW        = 2,
  parameter int ADDR_WIDTH    = 16,
  parameter int FW_ADDR_SHIFT = 12,
  parameter int RESP_TIMEOUT  = 1024,
  parameter int POLL_MAX      = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic [ADDR_WIDTH-1:0]       M_AXI_CTL_awaddr,
  output logic                        M_AXI_CTL_awvalid,
  input  logic                        M_AXI_CTL_awready,
  output logic [31:0]                 M_AXI_CTL_wdata,
  output logic [3:0]                  M_AXI_CTL_wstrb,
  output logic                        M_AXI_CTL_wvalid,
  input  logic                        M_AXI_CTL_wready,
  input  logic [1:0]                  M_AXI_CTL_bresp,
  input  logic                        M_AXI_CTL_bvalid,
  output logic                        M_AXI_CTL_bready,
  output logic [ADDR_WIDTH-1:0]       M_AXI_CTL_araddr,
  output logic                        M_AXI_CTL_arvalid,
  input  logic                        M_AXI_CTL_arready,
  input  logic [31:0]                 M_AXI_CTL_rdata,
  input  logic [1:0]                  M_AXI_CTL_rresp,
  input  logic                        M_AXI_CTL_rvalid,
  output logic                        M_AXI_CTL_rready,
  input  logic [NUM_FW-1:0]           mi_w_error,
  input  logic [NUM_FW-1:0]           mi_r_error,
  output logic                        busy,
  output logic [NUM_FW-1:0]           timeout_err,
  output logic [NUM_FW-1:0]           resp_err,
  output logic [NUM_FW*CNT_WIDTH-1:0] unblock_cnt
);

  localparam int IDX_W = idx_width(NUM_FW);
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
  localparam int PW    = $clog2(POLL_MAX + 1);

  fsm_state_e        state_q, state_d;
  logic              awv_q, awv_d;
  logic              wv_q, wv_d;
  logic              arv_q, arv_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [NUM_FW-1:0] tmo_q, tmo_d;
  logic [NUM_FW-1:0] rerr_q, rerr_d;
  logic [NUM_FW-1:0] err_q, err_d;
  logic [NUM_FW-1:0] armed_q, armed_d;

  logic [NUM_FW-1:0] req;
  logic [NUM_FW-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic [ADDR_WIDTH-1:0] base_addr;

  // Error flags are registered once before they form a request. This gives the documented
  // two-edge latency from error to AWVALID.
  assign err_d = mi_w_error | mi_r_error;
  assign req   = armed_q & err_q;
  assign busy  = (state_q != ST_IDLE);

  axi_fw_rr_arbiter #(
    .NUM_FW (NUM_FW),
    .IDX_W  (IDX_W)
  ) u_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req         (req),
    .grant_en    (state_q == ST_IDLE),
    .grant       (gnt),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  // Fixed AXI payloads. Both addresses follow the held selection.
  assign base_addr         = ADDR_WIDTH'(sel_q) << FW_ADDR_SHIFT;
  assign M_AXI_CTL_awaddr  = base_addr + ADDR_WIDTH'(UNBLOCK_OFFSET);
  assign M_AXI_CTL_araddr  = base_addr + ADDR_WIDTH'(STATUS_OFFSET);
  assign M_AXI_CTL_wdata   = UNBLOCK_WDATA;
  assign M_AXI_CTL_wstrb   = UNBLOCK_WSTRB;
  assign M_AXI_CTL_awvalid = awv_q;
  assign M_AXI_CTL_wvalid  = wv_q;
  assign M_AXI_CTL_arvalid = arv_q;
  assign M_AXI_CTL_bready  = 1'b1;
  assign M_AXI_CTL_rready  = 1'b1;
  assign timeout_err       = tmo_q;
  assign resp_err          = rerr_q;

  // Arming logic. A channel disarms when it is granted. It re-arms only after its errors have
  // cleared and it is no longer in service, so one error episode causes one unblock.
  always_comb begin
    armed_d = armed_q;
    for (int i = 0; i < NUM_FW; i++) begin
      if (gnt[i]) begin
        armed_d[i] = 1'b0;
      end else if (!err_q[i] && !(busy && (sel_q == IDX_W'(i)))) begin
        armed_d[i] = 1'b1;
      end
    end
  end

  // Sequencer next-state logic. All VALIDs come from flops, so READY has no combinational path to VALID.
  always_comb begin
    state_d = state_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    arv_d   = arv_q;
    timer_d = timer_q;
    poll_d  = poll_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    rerr_d  = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_WRITE;
          sel_d   = gnt_idx;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (awv_q && M_AXI_CTL_awready) awv_d = 1'b0;
        if (wv_q && M_AXI_CTL_wready)   wv_d  = 1'b0;
        if ((!awv_q || M_AXI_CTL_awready) && (!wv_q || M_AXI_CTL_wready)) begin
          state_d = ST_RESP;
          timer_d = '0;
        end
      end
      ST_RESP: begin
        if (M_AXI_CTL_bvalid) begin
          if (M_AXI_CTL_bresp != OKAY) rerr_d[sel_q] = 1'b1;
          state_d = ST_POLL_AR;
          arv_d   = 1'b1;
          poll_d  = '0;
        end else if (timer_q == TMR_W'(RESP_TIMEOUT)) begin
          tmo_d[sel_q] = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_POLL_AR: begin
        if (M_AXI_CTL_arready) begin
          arv_d   = 1'b0;
          state_d = ST_POLL_R;
        end
      end
      ST_POLL_R: begin
        if (M_AXI_CTL_rvalid) begin
          poll_d = poll_q + PW'(1);
          if (M_AXI_CTL_rresp != OKAY) begin
            rerr_d[sel_q] = 1'b1;
            state_d       = ST_IDLE;
          end else if (M_AXI_CTL_rdata == 32'h0) begin
            state_d = ST_IDLE;
          end else if (poll_d < PW'(POLL_MAX)) begin
            state_d = ST_POLL_AR;
            arv_d   = 1'b1;
          end else begin
            tmo_d[sel_q] = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        awv_d   = 1'b0;
        wv_d    = 1'b0;
        arv_d   = 1'b0;
      end
    endcase
  end

  // Sequencer, flag and arming registers. Reset drops every VALID immediately.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      timer_q <= '0;
      poll_q  <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      rerr_q  <= '0;
      err_q   <= '0;
      armed_q <= '1;
    end else begin
      state_q <= state_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      timer_q <= timer_d;
      poll_q  <= poll_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      rerr_q  <= rerr_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

`ifdef AXI_FW_UNBLOCK_CNT_EN
  logic cnt_inc;

  // A completed unblock is a clean status read that returns zero.
  assign cnt_inc = (state_q == ST_POLL_R) && M_AXI_CTL_rvalid &&
                   (M_AXI_CTL_rresp == OKAY) && (M_AXI_CTL_rdata == 32'h0);

  for (genvar gi = 0; gi < NUM_FW; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of completed unblocks for this channel.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc && (sel_q == IDX_W'(gi)) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    // Counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign unblock_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  assign unblock_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_firewall_multi_unblocker.sv
// Scoreboard bench for axi_firewall_multi_unblocker.
// The stimulus pushes the expected AW/W/AR beats into queues. A negedge responder/monitor acts as
// the firewall control slave and pops and checks each handshake as it happens.
module tb_axi_firewall_multi_unblocker;

  localparam int NUM_FW    = 2;
  localparam int AW        = 16;
  localparam int CNT_WIDTH = 16;
`ifdef AXI_FW_UNBLOCK_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, arvalid, bready, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;
  logic [NUM_FW-1:0] mi_w_error = '0, mi_r_error = '0;
  logic busy;
  logic [NUM_FW-1:0] timeout_err, resp_err;
  logic [NUM_FW*CNT_WIDTH-1:0] unblock_cnt;

  axi_firewall_multi_unblocker #(
    .NUM_FW(NUM_FW), .ADDR_WIDTH(AW), .FW_ADDR_SHIFT(12),
    .RESP_TIMEOUT(1024), .POLL_MAX(64), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .M_AXI_CTL_awaddr(awaddr), .M_AXI_CTL_awvalid(awvalid), .M_AXI_CTL_awready(awready),
    .M_AXI_CTL_wdata(wdata), .M_AXI_CTL_wstrb(wstrb), .M_AXI_CTL_wvalid(wvalid), .M_AXI_CTL_wready(wready),
    .M_AXI_CTL_bresp(bresp), .M_AXI_CTL_bvalid(bvalid), .M_AXI_CTL_bready(bready),
    .M_AXI_CTL_araddr(araddr), .M_AXI_CTL_arvalid(arvalid), .M_AXI_CTL_arready(arready),
    .M_AXI_CTL_rdata(rdata), .M_AXI_CTL_rresp(rresp), .M_AXI_CTL_rvalid(rvalid), .M_AXI_CTL_rready(rready),
    .mi_w_error(mi_w_error), .mi_r_error(mi_r_error),
    .busy(busy), .timeout_err(timeout_err), .resp_err(resp_err), .unblock_cnt(unblock_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Responder configuration, driven by the stimulus.
  int          aw_delay   = 0;
  bit          b_withhold = 1'b0;
  logic [1:0]  bresp_cfg  = 2'b00;
  logic [31:0] rdata_cfg  = 32'h0;

  // Scoreboard queues.
  logic [AW-1:0] exp_aw_addr_q[$];
  int            exp_aw_cyc_q[$];
  logic [35:0]   exp_w_q[$];
  logic [AW-1:0] exp_ar_q[$];

  // Responder state.
  int aw_cnt = 0, w_cnt = 0;
  bit aw_seen = 0, w_seen = 0, pend_b = 0, pend_r = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Firewall slave model and scoreboard monitor, evaluated on the falling edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0; pend_b = 0; pend_r = 0;
    end else begin
      // BREADY/RREADY are high, so last cycle's beats were consumed.
      bvalid = 0;
      rvalid = 0;
      if (pend_b && !b_withhold) begin
        bvalid = 1; bresp = bresp_cfg; pend_b = 0;
        $display("[TB] B  resp=%0d", bresp_cfg);
      end
      if (pend_r) begin
        rvalid = 1; rdata = rdata_cfg; rresp = 2'b00; pend_r = 0;
      end
      if (awvalid) begin aw_cnt++; awready = (aw_cnt > aw_delay); end
      else begin aw_cnt = 0; awready = 0; end
      if (wvalid) begin w_cnt++; wready = 1; end
      else begin w_cnt = 0; wready = 0; end
      arready = arvalid;

      if (awvalid && awready) begin
        $display("[TB] AW addr=0x%04h valid for %0d cycle(s)", awaddr, aw_cnt);
        check("aw_expected", exp_aw_addr_q.size() > 0, 1);
        if (exp_aw_addr_q.size() > 0) begin
          check("aw_addr", awaddr, exp_aw_addr_q.pop_front());
          check("aw_cycles", aw_cnt, exp_aw_cyc_q.pop_front());
        end
        aw_seen = 1;
      end
      if (wvalid && wready) begin
        $display("[TB] W  data=0x%08h strb=%b valid for %0d cycle(s)", wdata, wstrb, w_cnt);
        check("w_expected", exp_w_q.size() > 0, 1);
        if (exp_w_q.size() > 0) check("w_strb_data", {wstrb, wdata}, exp_w_q.pop_front());
        check("w_cycles", w_cnt, 1);
        w_seen = 1;
      end
      if (aw_seen && w_seen) begin pend_b = 1; aw_seen = 0; w_seen = 0; end
      if (arvalid && arready) begin
        $display("[TB] AR addr=0x%04h rdata_next=0x%0h", araddr, rdata_cfg);
        check("ar_expected", exp_ar_q.size() > 0, 1);
        if (exp_ar_q.size() > 0) check("ar_addr", araddr, exp_ar_q.pop_front());
        pend_r = 1;
      end
    end
  end

  task automatic expect_unblock(input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                                input int aw_cyc, input int npoll);
    exp_aw_addr_q.push_back(wa);
    exp_aw_cyc_q.push_back(aw_cyc);
    exp_w_q.push_back({4'b0001, 32'h0000_0001});
    for (int i = 0; i < npoll; i++) exp_ar_q.push_back(ra);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    repeat (4) @(negedge aclk);
    while ((exp_aw_addr_q.size() != 0 || exp_w_q.size() != 0 || exp_ar_q.size() != 0 || busy)
           && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check({name, "_done_in_budget"}, n < budget, 1);
    repeat (8) @(negedge aclk);
  endtask

  task automatic clear_errors();
    mi_w_error = '0;
    mi_r_error = '0;
    repeat (5) @(negedge aclk);
  endtask

  function automatic logic [15:0] cnt_of(input int ch);
    return unblock_cnt[ch*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_busy", busy, 0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("rst_flags", {timeout_err, resp_err}, 0);
    check("rst_cnt", unblock_cnt, 0);
    check("rst_ready_tie", {bready, rready}, 2'b11);

    // S1: write error on channel 1, status reads back clear at once
    expect_unblock(16'h1008, 16'h1000, 1, 1);
    mi_w_error = 2'b10;
    wait_quiet("s1", 50);
    check("s1_busy_low", busy, 0);
    check("s1_cnt1", cnt_of(1), CNT_ON * 1);
    check("s1_cnt0", cnt_of(0), 0);
    repeat (20) @(negedge aclk);   // error still held: any extra beat is flagged by the monitor
    clear_errors();
    expect_unblock(16'h1008, 16'h1000, 1, 1);
    mi_w_error = 2'b10;
    wait_quiet("s1_rearm", 50);
    check("s1_cnt1_again", cnt_of(1), CNT_ON * 2);
    clear_errors();

    // S2: both channels request together; channel 0 goes first
    expect_unblock(16'h0008, 16'h0000, 1, 1);
    expect_unblock(16'h1008, 16'h1000, 1, 1);
    mi_r_error = 2'b11;
    wait_quiet("s2", 100);
    check("s2_cnt0", cnt_of(0), CNT_ON * 1);
    check("s2_cnt1", cnt_of(1), CNT_ON * 3);
    clear_errors();

    // S3: AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    expect_unblock(16'h0008, 16'h0000, 4, 1);
    mi_w_error = 2'b01;
    wait_quiet("s3", 50);
    check("s3_cnt0", cnt_of(0), CNT_ON * 2);
    aw_delay = 0;
    clear_errors();

    // S4: B withheld, so the response timer expires
    b_withhold = 1'b1;
    exp_aw_addr_q.push_back(16'h0008);
    exp_aw_cyc_q.push_back(1);
    exp_w_q.push_back({4'b0001, 32'h1});
    mi_w_error = 2'b01;
    n = 0;
    while (!busy && n < 20) begin @(negedge aclk); n++; end
    check("s4_busy_rise", busy, 1);
    n = 0;
    while (busy && n < 1200) begin @(negedge aclk); n++; end
    check("s4_busy_fall", busy, 0);
    check("s4_duration_1024_to_1040", (n >= 1024) && (n <= 1040), 1);
    check("s4_timeout_err", timeout_err, 2'b01);
    b_withhold = 1'b0;             // late B now arrives and must be ignored
    repeat (10) @(negedge aclk);
    check("s4_late_b_busy", busy, 0);
    check("s4_late_b_flags", {timeout_err, resp_err}, {2'b01, 2'b00});
    check("s4_cnt0", cnt_of(0), CNT_ON * 2);
    clear_errors();

    // S5: status stays nonzero for all 64 polls
    rdata_cfg = 32'h1;
    expect_unblock(16'h1008, 16'h1000, 1, 64);
    mi_r_error = 2'b10;
    wait_quiet("s5", 2000);
    check("s5_timeout_err", timeout_err, 2'b11);
    check("s5_cnt1", cnt_of(1), CNT_ON * 3);
    rdata_cfg = 32'h0;
    clear_errors();

    // S6: SLVERR on B; polling still proceeds
    bresp_cfg = 2'b10;
    expect_unblock(16'h0008, 16'h0000, 1, 1);
    mi_w_error = 2'b01;
    wait_quiet("s6", 50);
    check("s6_resp_err", resp_err, 2'b01);
    check("s6_cnt0", cnt_of(0), CNT_ON * 3);
    bresp_cfg = 2'b00;
    clear_errors();

    // S7: asynchronous reset in the middle of WRITE
    aw_delay = 20;
    exp_w_q.push_back({4'b0001, 32'h1});
    mi_w_error = 2'b10;
    n = 0;
    while (!awvalid && n < 20) begin @(negedge aclk); n++; end
    check("s7_awvalid_up", awvalid, 1);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("s7_async_valids", {awvalid, wvalid, arvalid}, 3'b000);
    check("s7_async_busy", busy, 0);
    check("s7_async_flags", {timeout_err, resp_err}, 0);
    check("s7_async_cnt", unblock_cnt, 0);
    exp_aw_addr_q.delete(); exp_aw_cyc_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    aw_delay = 0;
    expect_unblock(16'h1008, 16'h1000, 1, 1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    wait_quiet("s7_recover", 50);
    check("s7_cnt1", cnt_of(1), CNT_ON * 1);
    check("s7_flags", {timeout_err, resp_err}, 0);
    clear_errors();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
